seq_param_alu: RTL and testbench
================================

// Module: seq_param_alu
// PURPOSE
//   Parametrised, clocked successor to the combinational 16-bit ALU: add, subtract,
//   multiply and barrel shift over WIDTH-bit operands behind a valid/ready handshake.
//   The multiply is a sequential shift-add unit, one partial product per cycle.
//   All other ops complete in one cycle. The result is held until the consumer accepts it.
//   Sits between the operand register file and the result writeback stage.
// PARAMETERS
//   WIDTH   16   operand width in bits; legal range >= 4; the result is 2*WIDTH bits
//   CNT_W   $clog2(WIDTH+1)  localparam, multiply iteration counter width (not overridable)
// PORTS
//   clk        in   1        single clock; all state updates on the rising edge
//   rst        in   1        asynchronous, active-high reset
//   in_valid   in   1        op, a, b and cin are valid
//   in_ready   out  1        block can accept an op; high only in IDLE
//   op         in   2        00 ADD, 01 SUB, 10 MUL (unsigned), 11 SHIFT
//   a          in   WIDTH    operand A
//   b          in   WIDTH    operand B
//   cin        in   1        carry-in; used by ADD only
//   out_valid  out  1        result, carry and zero are valid
//   out_ready  in   1        consumer accepts the result
//   result     out  2*WIDTH  packed result, see BEHAVIOUR
//   carry      out  1        op-dependent flag
//   zero       out  1        op-dependent zero flag
// BEHAVIOUR
//   Reset: state=IDLE, out_valid=0, result=0, carry=0, zero=0, multiply regs=0.
//     Applies immediately, including mid-multiply; any op in flight is dropped.
//   Accept: an op is accepted on a rising edge when in_valid && in_ready.
//     Operands are captured at accept; input changes afterwards have no effect.
//   FSM:
//     IDLE -accept ADD/SUB/SHIFT-> DONE
//     IDLE -accept MUL-> MUL
//     MUL  -after WIDTH iterations-> DONE
//     DONE -out_ready-> IDLE
//   Latency:
//     ADD/SUB/SHIFT: out_valid is high in the cycle after the accept edge.
//     MUL: out_valid is high exactly WIDTH cycles after the accept edge.
//   DONE: result, carry and zero are held stable while out_valid && !out_ready.
//     in_ready=0 in DONE, so in_valid is ignored even when out_ready=1 that cycle.
//     Peak throughput is therefore one op per 2 cycles.
//   ADD:   result = zero-extended {cout, a+b+cin} (WIDTH+1 bits); carry = cout.
//   SUB:   result[WIDTH-1:0] = b - a, computed as b + ~a + 1; upper bits = 0.
//          carry = 1 when there is no borrow (b >= a).
//   MUL:   acc = 0, mq = b. Each iteration:
//            {c, acc} = acc + (mq[0] ? a : 0)
//            {c, acc, mq} shifts right by 1
//          Product = {acc, mq}. carry = 1 when the upper WIDTH bits are nonzero.
//   SHIFT: result = {a << b, a >> b}, both logical. The shift amount is the full
//          unsigned b; if b >= WIDTH both halves are 0. carry = 0.
//   zero:  = (result[WIDTH-1:0] == 0) for ADD, SUB and SHIFT.
//          = (full product == 0) for MUL.
// STRUCTURE
//   Package seq_alu_pkg:
//     localparams OP_ADD, OP_SUB, OP_MUL, OP_SHIFT (2-bit)
//     state encoding ST_IDLE, ST_MUL, ST_DONE
//   Sub-module shift_add_mul: sequential multiplier datapath
//     holds acc, mq and the counter; ports start, a, b -> done, product
//   The top holds the FSM, handshake, single-cycle ops, output registers and flags.
// TESTING (WIDTH=16 unless noted)
//   1. ADD a=FFFF b=0001 cin=0 -> next cycle out_valid=1, result=0x00010000, carry=1, zero=1.
//      ADD a=1234 b=1111 cin=1 -> result=0x2346, carry=0.
//   2. SUB a=0005 b=0003 -> result=0xFFFE, carry=0.
//      SUB a=0003 b=0005 -> result=0x0002, carry=1.
//   3. MUL a=FFFF b=FFFF -> out_valid exactly 16 cycles after accept, result=0xFFFE0001, carry=1.
//      MUL a=0 b=1234 -> result=0, zero=1.
//   4. SHIFT a=8001 b=1 -> result={0x0002,0x4000}.
//      SHIFT b=16 or b=FFFF -> result=0, zero=1.
//   5. Backpressure: hold out_ready=0 for 5 cycles after a MUL completes with in_valid=1
//      -> result stable, in_ready=0, no new accept. Raise out_ready -> IDLE next edge, then accept.
//   6. Assert rst asynchronously 7 cycles into a MUL -> out_valid=0 and result=0 with no clock edge.
//      After release, in_ready=1 and ADD 2+3 returns result=5.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential parametrised ALU.
package seq_alu_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_MUL   = 2'b10;
    localparam logic [1:0] OP_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_param_alu_shift_add_mul.sv
// Shift-add unsigned multiplier: one partial product per cycle, WIDTH iterations.
// done flags the final iteration; product is the value that iteration produces.
module shift_add_mul #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;

    always_comb begin
        acc_d = acc_q;
        mq_d  = mq_q;
        a_d   = a_q;
        cnt_d = cnt_q;
        sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        if (start) begin
            acc_d = '0;
            mq_d  = b;
            a_d   = a;
            cnt_d = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            // {carry, acc, mq} shifted right by one after the conditional add
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign done    = (cnt_q == CNT_W'(1)) && !start;
    assign product = {sum[WIDTH:1], sum[0], mq_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            mq_q  <= '0;
            a_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            mq_q  <= mq_d;
            a_q   <= a_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_param_alu.sv
// Clocked ALU (add/sub/mul/shift) behind valid/ready, result held until accepted.
//   state   | meaning
//   IDLE    | in_ready high, waiting for an op
//   MUL     | shift-add multiplier iterating
//   DONE    | out_valid high, result held until out_ready
module seq_param_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 carry,
    output logic                 zero
);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic                 zero_q, zero_d;

    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic [WIDTH-1:0]     shl;
    logic [WIDTH-1:0]     shr;
    logic                 shift_big;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
    );

    assign add_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_diff  = {1'b0, b} + {1'b0, ~a} + (WIDTH+1)'(1);
    // The whole of b is the shift amount, so large values must flush to zero
    assign shift_big = (b >= WIDTH'(WIDTH));
    assign shl       = shift_big ? '0 : (a << b);
    assign shr       = shift_big ? '0 : (a >> b);

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (op)
                        OP_ADD: begin
                            result_d = {{(WIDTH-1){1'b0}}, add_sum};
                            carry_d  = add_sum[WIDTH];
                            zero_d   = (add_sum[WIDTH-1:0] == '0);
                            state_d  = ST_DONE;
                        end
                        OP_SUB: begin
                            result_d = {{WIDTH{1'b0}}, sub_diff[WIDTH-1:0]};
                            carry_d  = sub_diff[WIDTH];
                            zero_d   = (sub_diff[WIDTH-1:0] == '0);
                            state_d  = ST_DONE;
                        end
                        OP_MUL: begin
                            mul_start = 1'b1;
                            state_d   = ST_MUL;
                        end
                        default: begin
                            result_d = {shl, shr};
                            carry_d  = 1'b0;
                            zero_d   = (shr == '0);
                            state_d  = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_d = mul_product;
                    carry_d  = (mul_product[2*WIDTH-1:WIDTH] != '0);
                    zero_d   = (mul_product == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_seq_param_alu.sv
// Bench for seq_param_alu at WIDTH=16: directed vectors plus random ops vs a reference model.
module tb_seq_param_alu;
    import seq_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry;
    logic        zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_param_alu #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {result[31:0], carry, zero} computed with plain integer arithmetic
    function automatic logic [33:0] ref_alu(input logic [1:0] o, input logic [15:0] x,
                                           input logic [15:0] y, input logic ci);
        longint unsigned xa, yb, r;
        logic c, z;
        xa = 64'(x);
        yb = 64'(y);
        case (o)
            OP_ADD: begin
                r = xa + yb + 64'(ci);
                c = (r >= 64'h10000);
                z = ((r & 64'hFFFF) == 0);
            end
            OP_SUB: begin
                r = (yb - xa) & 64'hFFFF;
                c = (yb >= xa);
                z = (r == 0);
            end
            OP_MUL: begin
                r = xa * yb;
                c = (r >= 64'h10000);
                z = (r == 0);
            end
            default: begin
                if (yb >= 16) r = 0;
                else r = (((xa << yb) & 64'hFFFF) << 16) | (xa >> yb);
                c = 1'b0;
                z = ((r & 64'hFFFF) == 0);
            end
        endcase
        return {r[31:0], c, z};
    endfunction

    // Caller sits just after a rising edge. Leaves the DUT in DONE when rel=0.
    task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input int hold, input bit rel,
                         output logic [31:0] r_obs);
        logic [33:0] e;
        int w;
        int lat;
        e = ref_alu(o, x, y, ci);
        op = o; a = x; b = y; cin = ci;
        in_valid = 1'b1;
        out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        op  = 2'($urandom);
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), (o == OP_MUL) ? 64'(16) : 64'(0));
        chk("result", 64'(result), 64'(e[33:2]));
        chk("carry", 64'(carry), 64'(e[1]));
        chk("zero", 64'(zero), 64'(e[0]));
        r_obs = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_result", 64'(result), 64'(e[33:2]));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
        end
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk("release_valid", 64'(out_valid), 64'(0));
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] held;
        logic [1:0]  ro;
        logic [15:0] ra, rb;

        #12;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_carry", 64'(carry), 64'(0));
        chk("rst_zero", 64'(zero), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1, 1'b1, r);
        chk("add_ffff_1", 64'(r), 64'h0001_0000);
        do_op(OP_ADD, 16'h1234, 16'h1111, 1'b1, 0, 1'b1, r);
        chk("add_cin", 64'(r), 64'h0000_2346);
        do_op(OP_SUB, 16'h0005, 16'h0003, 1'b0, 0, 1'b1, r);
        chk("sub_borrow", 64'(r), 64'h0000_FFFE);
        do_op(OP_SUB, 16'h0003, 16'h0005, 1'b0, 0, 1'b1, r);
        chk("sub_noborrow", 64'(r), 64'h0000_0002);
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b1, r);
        chk("mul_max", 64'(r), 64'hFFFE_0001);
        do_op(OP_MUL, 16'h0000, 16'h1234, 1'b0, 0, 1'b1, r);
        chk("mul_zero", 64'(r), 64'h0);
        do_op(OP_SHIFT, 16'h8001, 16'h0001, 1'b0, 0, 1'b1, r);
        chk("shift_1", 64'(r), 64'h0002_4000);
        do_op(OP_SHIFT, 16'h8001, 16'd16, 1'b0, 0, 1'b1, r);
        chk("shift_16", 64'(r), 64'h0);
        do_op(OP_SHIFT, 16'h8001, 16'hFFFF, 1'b0, 0, 1'b1, r);
        chk("shift_ffff", 64'(r), 64'h0);

        // Backpressure: MUL completes, consumer stalls with a new op pending
        do_op(OP_MUL, 16'h1234, 16'h5678, 1'b0, 0, 1'b0, held);
        op = OP_ADD; a = 16'd7; b = 16'd8; cin = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_result", 64'(result), 64'h0626_0060);
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_valid", 64'(out_valid), 64'(0));
        chk("bp_idle_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept_valid", 64'(out_valid), 64'(1));
        chk("bp_accept_result", 64'(result), 64'd15);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Async reset in the middle of a multiply; result holds a nonzero value beforehand
        do_op(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b1, r);
        op = OP_MUL; a = 16'h00FF; b = 16'h0F0F;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'(0));
        chk("arst_result", 64'(result), 64'(0));
        chk("arst_carry", 64'(carry), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_in_ready", 64'(in_ready), 64'(1));
        do_op(OP_ADD, 16'd2, 16'd3, 1'b0, 0, 1'b1, r);
        chk("arst_add", 64'(r), 64'd5);

        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (ro == OP_SHIFT && ($urandom_range(0, 3) != 0)) rb = 16'($urandom_range(0, 20));
            if ($urandom_range(0, 7) == 0) ra = 16'h0;
            do_op(ro, ra, rb, 1'($urandom), $urandom_range(0, 2), 1'b1, r);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
